// File: rtl/rbcp_responder.sv
// RBCP slave register bank for the SiTCP user side: RW control bytes, a pulse
// register, RO status bytes and a saturating clear-on-read event counter.
module rbcp_responder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned NUM_RW    = 8,
    parameter int unsigned NUM_RO    = 4
) (
    input  logic                  SYSCLK,
    input  logic                  RSTn,
    input  logic                  rbcp_act,
    input  logic [31:0]           rbcp_addr,
    input  logic [7:0]            rbcp_wd,
    input  logic                  rbcp_we,
    input  logic                  rbcp_re,
    output logic                  rbcp_ack,
    output logic [7:0]            rbcp_rd,
    output logic [8*NUM_RW-1:0]   ctrl_regs,
    output logic [7:0]            pulse_out,
    input  logic [8*NUM_RO-1:0]   status_in,
    input  logic                  event_in,
    output logic                  access_err
);

    localparam logic [31:0] PULSE_OFF = 32'(NUM_RW);
    localparam logic [31:0] EV_OFF    = 32'(NUM_RW + NUM_RO + 1);

    logic [7:0]  rw_q [NUM_RW];
    logic [7:0]  ev_cnt;
    logic [31:0] off;
    logic        in_range;
    logic        acc;
    logic        acc_ok;
    logic        wr_ok;
    logic        rd_ok;
    logic [7:0]  rd_mux;

    // Every offset from 0 to EV_OFF is mapped, so range is a single compare
    // once addresses below the base are rejected (no wrap-around).
    always_comb begin
        off      = rbcp_addr - BASE_ADDR;
        in_range = (rbcp_addr >= BASE_ADDR) && (off <= EV_OFF);
        acc      = rbcp_act && (rbcp_we || rbcp_re);
        acc_ok   = acc && in_range;
        wr_ok    = acc_ok && rbcp_we;
        rd_ok    = acc_ok && !rbcp_we;
    end

    always_comb begin
        rd_mux = '0;
        for (int unsigned k = 0; k < NUM_RW; k++)
            if (off == 32'(k)) rd_mux = rw_q[k];
        for (int unsigned k = 0; k < NUM_RO; k++)
            if (off == 32'(NUM_RW + 1 + k)) rd_mux = status_in[8*k +: 8];
        if (off == EV_OFF) rd_mux = ev_cnt;
    end

    always_comb begin
        ctrl_regs = '0;
        for (int unsigned k = 0; k < NUM_RW; k++)
            ctrl_regs[8*k +: 8] = rw_q[k];
    end

    always_ff @(posedge SYSCLK or negedge RSTn) begin
        if (!RSTn) begin
            rbcp_ack   <= 1'b0;
            rbcp_rd    <= '0;
            pulse_out  <= '0;
            access_err <= 1'b0;
            for (int unsigned k = 0; k < NUM_RW; k++)
                rw_q[k] <= '0;
        end else begin
            rbcp_ack   <= acc_ok;
            access_err <= acc && !in_range;
            rbcp_rd    <= rd_ok ? rd_mux : 8'h00;
            pulse_out  <= (wr_ok && off == PULSE_OFF) ? rbcp_wd : 8'h00;
            for (int unsigned k = 0; k < NUM_RW; k++)
                if (wr_ok && off == 32'(k)) rw_q[k] <= rbcp_wd;
        end
    end

    // A read-clear restarts from the current cycle's event, so an event
    // coincident with the read is never lost.
    always_ff @(posedge SYSCLK or negedge RSTn) begin
        if (!RSTn) begin
            ev_cnt <= '0;
        end else if (rd_ok && off == EV_OFF) begin
            ev_cnt <= event_in ? 8'h01 : 8'h00;
        end else if (event_in && ev_cnt != 8'hFF) begin
            ev_cnt <= ev_cnt + 8'h01;
        end
    end

endmodule

// File: doc/rbcp_responder.md
Name: rbcp_responder

Overview:
- RBCP slave register bank on the user side of the SiTCP core. It terminates the RBCP_ACT/ADDR/WD/WE/RE strobes from SiTCP and returns RBCP_ACK/RBCP_RD.
- It provides byte-wide read/write control registers, a self-clearing pulse register, read-only status bytes and a clear-on-read event counter.
- Runs entirely in the SiTCP system clock domain.

Parameters:
- BASE_ADDR, 32'h0000_0000, first RBCP address decoded by this block.
- NUM_RW, 8, number of read/write control bytes (1..64).
- NUM_RO, 4, number of read-only status bytes (1..64).

Ports:
- SYSCLK  in  1  system clock, same clock as the SiTCP CLK.
- RSTn  in  1  reset, asynchronous assert, active-low.
- rbcp_act  in  1  RBCP transaction active.
- rbcp_addr  in  32  RBCP byte address.
- rbcp_wd  in  8  RBCP write data.
- rbcp_we  in  1  RBCP write strobe, 1 cycle.
- rbcp_re  in  1  RBCP read strobe, 1 cycle.
- rbcp_ack  out  1  access acknowledge, 1-cycle pulse.
- rbcp_rd  out  8  read data, valid only while rbcp_ack=1.
- ctrl_regs  out  8*NUM_RW  RW bytes; byte k occupies bits [8k+7:8k].
- pulse_out  out  8  one-cycle strobes from pulse-register writes.
- status_in  in  8*NUM_RO  RO status bytes, sampled at read time.
- event_in  in  1  event strobe; each SYSCLK cycle high counts 1.
- access_err  out  1  1-cycle pulse on an out-of-range access.

Behaviour:
- Reset (RSTn=0, async): rbcp_ack=0, rbcp_rd=8'h00, ctrl_regs=0, pulse_out=0, event counter=0, access_err=0.
- Offset decode: off = rbcp_addr - BASE_ADDR, 32-bit unsigned. An address below BASE_ADDR is out of range (no wrap). Map:
  - 0..NUM_RW-1: RW control bytes.
  - NUM_RW: PULSE register.
  - NUM_RW+1 .. NUM_RW+NUM_RO: status_in bytes 0..NUM_RO-1.
  - NUM_RW+NUM_RO+1: EVCNT.
  - Everything else: out of range.
- A strobe is accepted only when rbcp_act=1 in the same cycle. we/re with rbcp_act=0 are ignored: no ack, no side effect.
- Accepted access in cycle N: all side effects and the ack occur at the edge ending cycle N. rbcp_ack=1 in cycle N+1 only (fixed latency 1). rbcp_rd carries data in N+1 and returns to 8'h00 in N+2.
- Write:
  - RW byte: load rbcp_wd; visible on ctrl_regs in N+1.
  - PULSE: pulse_out=rbcp_wd for cycle N+1 only, then 0.
  - RO/EVCNT: data discarded; still acked.
- Read:
  - RW byte: current value.
  - PULSE: 8'h00.
  - RO byte: status_in byte registered at edge N.
  - EVCNT: counter value before clear; counter then clears.
- we and re both high in the same cycle: treated as a write only. One ack, rbcp_rd=8'h00.
- Out of range: no rbcp_ack (SiTCP times out and reports a bus error). access_err=1 in N+1. No state changes.
- Back-to-back strobes in N and N+1: both serviced, acks in N+1 and N+2.
- EVCNT: 8-bit, +1 per cycle with event_in=1, saturates at 8'hFF.
  - Read-clear in the same cycle as event_in=1: read returns the old value, counter becomes 8'h01.
  - Read-clear while saturated: returns FF, counter becomes 0 (or 1 if event_in=1 in that cycle).
- Reset mid-transaction: pending ack and pulse are dropped immediately; no ack after RSTn deasserts for a strobe issued before reset.
- No other state machine: the block is a single registered stage plus the counter.

Test Plan:
- Reset, then write 8'hA5 to BASE_ADDR+3 and read it back -> ack 1 cycle after each strobe; ctrl_regs[31:24]=A5; read rbcp_rd=A5 with ack; rd=00 the cycle after.
- Write 8'h81 to PULSE (off=8) -> pulse_out=81 for exactly one cycle, then 00; read PULSE -> 00.
- status_in byte 2=8'h3C, read off=11 -> rbcp_rd=3C; write 8'hFF to off=11 -> acked, read still returns 3C.
- 300 cycles of event_in=1, read off=13 -> FF, next read -> 00. 5 events, then a read with event_in=1 in the strobe cycle -> 05; next read -> 01.
- Access at BASE_ADDR+14 and at BASE_ADDR-1 (BASE=0x100) -> no ack, access_err pulse, ctrl_regs unchanged. rbcp_we with rbcp_act=0 -> no ack, no write.
- we+re simultaneously on off=0 with wd=5A -> single ack, rd=00, ctrl_regs[7:0]=5A. Assert RSTn low in the ack cycle -> ack drops at once, all registers cleared.
